// File: rtl/conv_frame_ctrl_if.sv
// Handshake and strobe bundle between the frame sequencer, its bit source and the encoder.
// The controller sits on the slave side of this interface.
interface conv_frame_ctrl_if;
    logic        start;
    logic        src_valid;
    logic        src_bit;
    logic        src_ready;
    logic        enc_din;
    logic        enc_en;
    logic        enc_clr;
    logic        sym_valid;
    logic        sym_sof;
    logic        sym_eof;
    logic [15:0] frame_cnt;
    logic        underrun;
    logic        busy;
    logic [1:0]  fsm_state;

    modport master (
        output start, src_valid, src_bit,
        input  src_ready, enc_din, enc_en, enc_clr, sym_valid, sym_sof, sym_eof,
        input  frame_cnt, underrun, busy, fsm_state
    );

    modport slave (
        input  start, src_valid, src_bit,
        output src_ready, enc_din, enc_en, enc_clr, sym_valid, sym_sof, sym_eof,
        output frame_cnt, underrun, busy, fsm_state
    );
endinterface

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer for the rate-1/2 K=3 convolutional encoder: pulls message bits, appends
// the zero flush tail, inserts idle gaps and aligns symbol markers to the encoder latency.
module conv_frame_ctrl #(
    parameter int INFO_LEN = 29,
    parameter int TAIL_LEN = 2,
    parameter int GAP_LEN  = 0,
    parameter int ENC_LAT  = 2
) (
    input logic             clk,
    input logic             reset,
    conv_frame_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        TAIL = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam logic [7:0] INFO_LAST = 8'(INFO_LEN - 1);
    localparam logic [7:0] TAIL_LAST = 8'(TAIL_LEN - 1);
    localparam logic [7:0] GAP_LAST  = 8'(GAP_LEN - 1);

    state_t               state;
    logic [7:0]           bit_cnt;
    logic [7:0]           tail_cnt;
    logic [7:0]           gap_cnt;
    logic                 enc_en_q;
    logic                 enc_din_q;
    logic                 enc_clr_q;
    logic                 enc_sof_q;
    logic                 enc_eof_q;
    logic                 underrun_q;
    logic [15:0]          frame_cnt_q;
    logic [ENC_LAT-1:0]   pipe_en;
    logic [ENC_LAT-1:0]   pipe_sof;
    logic [ENC_LAT-1:0]   pipe_eof;

    // Source handshake: a bit transfers on a rising edge where src_valid && src_ready.
    // src_ready depends on state only, so it never waits on src_valid.
    assign bus.src_ready = (state == DATA);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= 8'd0;
            tail_cnt    <= 8'd0;
            gap_cnt     <= 8'd0;
            enc_en_q    <= 1'b0;
            enc_din_q   <= 1'b0;
            enc_clr_q   <= 1'b0;
            enc_sof_q   <= 1'b0;
            enc_eof_q   <= 1'b0;
            underrun_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
            pipe_en     <= '0;
            pipe_sof    <= '0;
            pipe_eof    <= '0;
        end else begin
            enc_en_q   <= 1'b0;
            enc_din_q  <= 1'b0;
            enc_clr_q  <= 1'b0;
            enc_sof_q  <= 1'b0;
            enc_eof_q  <= 1'b0;
            underrun_q <= 1'b0;

            // A frame counts as complete once its last tail strobe has been issued.
            frame_cnt_q <= frame_cnt_q + 16'(enc_eof_q);

            pipe_en[0]  <= enc_en_q;
            pipe_sof[0] <= enc_sof_q;
            pipe_eof[0] <= enc_eof_q;
            for (int i = 1; i < ENC_LAT; i++) begin
                pipe_en[i]  <= pipe_en[i-1];
                pipe_sof[i] <= pipe_sof[i-1];
                pipe_eof[i] <= pipe_eof[i-1];
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        enc_clr_q <= 1'b1;
                        bit_cnt   <= 8'd0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (bus.src_valid) begin
                        enc_en_q  <= 1'b1;
                        enc_din_q <= bus.src_bit;
                        enc_sof_q <= (bit_cnt == 8'd0);
                        bit_cnt   <= bit_cnt + 8'd1;
                        if (bit_cnt == INFO_LAST) begin
                            tail_cnt <= 8'd0;
                            state    <= TAIL;
                        end
                    end else begin
                        underrun_q <= 1'b1;
                    end
                end
                TAIL: begin
                    enc_en_q <= 1'b1;
                    tail_cnt <= tail_cnt + 8'd1;
                    if (tail_cnt == TAIL_LAST) begin
                        enc_eof_q <= 1'b1;
                        bit_cnt   <= 8'd0;
                        // start is only looked at here and at the end of the gap.
                        if (GAP_LEN > 0) begin
                            gap_cnt <= 8'd0;
                            state   <= GAP;
                        end else if (bus.start) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 8'd1;
                    if (gap_cnt == GAP_LAST) begin
                        state <= bus.start ? DATA : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.enc_en    = enc_en_q;
    assign bus.enc_din   = enc_din_q;
    assign bus.enc_clr   = enc_clr_q;
    assign bus.underrun  = underrun_q;
    assign bus.frame_cnt = frame_cnt_q;
    assign bus.sym_valid = pipe_en[ENC_LAT-1];
    assign bus.sym_sof   = pipe_sof[ENC_LAT-1];
    assign bus.sym_eof   = pipe_eof[ENC_LAT-1];
    assign bus.busy      = (state != IDLE) || enc_en_q || (|pipe_en);
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Bench for conv_frame_ctrl: two instances (no gap, 3-cycle gap) share one stimulus stream
// and are compared every cycle against a frame-position model, plus directed trace checks.
`timescale 1ns/1ps
module tb_conv_frame_ctrl;
    localparam int INFO  = 4;
    localparam int TAIL  = 2;
    localparam int LAT   = 2;
    localparam int GAP_A = 0;
    localparam int GAP_B = 3;
    localparam int NCYC  = 512;

    // Trace bit positions within the packed output vector.
    localparam int B_EN = 8, B_DIN = 7, B_CLR = 6, B_SV = 5, B_SOF = 4, B_EOF = 3;
    localparam int B_UND = 2, B_RDY = 1, B_BUSY = 0;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic st_in = 1'b0;
    logic v_in  = 1'b0;
    logic b_in  = 1'b0;

    conv_frame_ctrl_if b0 ();
    conv_frame_ctrl_if b1 ();

    assign b0.start = st_in;  assign b0.src_valid = v_in;  assign b0.src_bit = b_in;
    assign b1.start = st_in;  assign b1.src_valid = v_in;  assign b1.src_bit = b_in;

    conv_frame_ctrl #(.INFO_LEN(INFO), .TAIL_LEN(TAIL), .GAP_LEN(GAP_A), .ENC_LAT(LAT)) dut0 (
        .clk(clk), .reset(reset), .bus(b0));
    conv_frame_ctrl #(.INFO_LEN(INFO), .TAIL_LEN(TAIL), .GAP_LEN(GAP_B), .ENC_LAT(LAT)) dut1 (
        .clk(clk), .reset(reset), .bus(b1));

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Model: where each instance is inside its frame, tracked as a symbol position.
    bit          m_active [2];
    int          m_pos    [2];
    int          m_gap    [2];
    logic        m_din    [2];
    logic        m_clr    [2];
    logic        m_und    [2];
    logic [15:0] m_fc     [2];
    logic [LAT:0] m_hen   [2];
    logic [LAT:0] m_hsof  [2];
    logic [LAT:0] m_heof  [2];

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 1'b0; m_pos[k] = 0; m_gap[k] = 0;
            m_din[k] = 1'b0; m_clr[k] = 1'b0; m_und[k] = 1'b0; m_fc[k] = 16'd0;
            m_hen[k] = '0; m_hsof[k] = '0; m_heof[k] = '0;
        end
    endtask

    task automatic model_step(input int k);
        int   gap_len;
        logic n_en, n_sof, n_eof;
        gap_len = (k == 0) ? GAP_A : GAP_B;
        n_en = 1'b0; n_sof = 1'b0; n_eof = 1'b0;
        m_din[k] = 1'b0; m_clr[k] = 1'b0; m_und[k] = 1'b0;
        m_fc[k] = m_fc[k] + 16'(m_heof[k][0]);
        if (!m_active[k]) begin
            if (st_in) begin
                m_active[k] = 1'b1; m_pos[k] = 0; m_clr[k] = 1'b1;
            end
        end else if (m_gap[k] > 0) begin
            m_gap[k]--;
            if (m_gap[k] == 0 && !st_in) m_active[k] = 1'b0;
        end else if (m_pos[k] < INFO) begin
            if (v_in) begin
                n_en = 1'b1; m_din[k] = b_in; n_sof = (m_pos[k] == 0); m_pos[k]++;
            end else begin
                m_und[k] = 1'b1;
            end
        end else begin
            n_en = 1'b1; n_eof = (m_pos[k] == INFO + TAIL - 1); m_pos[k]++;
            if (m_pos[k] == INFO + TAIL) begin
                m_pos[k] = 0;
                if (gap_len > 0) m_gap[k] = gap_len;
                else if (!st_in) m_active[k] = 1'b0;
            end
        end
        m_hen[k]  = {m_hen[k][LAT-1:0], n_en};
        m_hsof[k] = {m_hsof[k][LAT-1:0], n_sof};
        m_heof[k] = {m_heof[k][LAT-1:0], n_eof};
    endtask

    initial model_reset();

    always @(posedge clk or negedge reset) begin
        if (!reset) model_reset();
        else for (int k = 0; k < 2; k++) model_step(k);
    end

    // Scoreboard: per-cycle compare of both instances, and a trace for the directed checks.
    int         cyc = 0;
    logic [8:0] tr [2][NCYC];
    logic [8:0] act_v [2];
    logic [8:0] exp_v;
    logic [15:0] fc_v [2];
    logic       exp_q [$];

    always @(negedge clk) begin
        act_v[0] = {b0.enc_en, b0.enc_din, b0.enc_clr, b0.sym_valid, b0.sym_sof, b0.sym_eof,
                    b0.underrun, b0.src_ready, b0.busy};
        act_v[1] = {b1.enc_en, b1.enc_din, b1.enc_clr, b1.sym_valid, b1.sym_sof, b1.sym_eof,
                    b1.underrun, b1.src_ready, b1.busy};
        fc_v[0] = b0.frame_cnt;
        fc_v[1] = b1.frame_cnt;
        for (int k = 0; k < 2; k++) begin
            exp_v = {m_hen[k][0], m_din[k], m_clr[k], m_hen[k][LAT], m_hsof[k][LAT],
                     m_heof[k][LAT], m_und[k],
                     (m_active[k] && m_gap[k] == 0 && m_pos[k] < INFO),
                     (m_active[k] || (|m_hen[k]))};
            check("outputs", k, 32'(act_v[k]), 32'(exp_v));
            check("frame_cnt", k, 32'(fc_v[k]), 32'(m_fc[k]));
            if (cyc < NCYC) tr[k][cyc] = act_v[k];
        end
        cyc++;
    end

    function automatic int count_of(input int k, input int b, input int a, input int z);
        int n = 0;
        for (int i = a; i < z && i < NCYC; i++) if (tr[k][i][b]) n++;
        return n;
    endfunction

    function automatic int nth_of(input int k, input int b, input int n, input int a, input int z);
        int seen = 0;
        for (int i = a; i < z && i < NCYC; i++) begin
            if (tr[k][i][b]) begin
                seen++;
                if (seen == n) return i;
            end
        end
        return -1;
    endfunction

    function automatic int last_of(input int k, input int b, input int a, input int z);
        int r = -1;
        for (int i = a; i < z && i < NCYC; i++) if (tr[k][i][b]) r = i;
        return r;
    endfunction

    // Driver: inputs change just after the falling edge, well away from the rising edge.
    task automatic drive(input logic st, input logic v, input logic bt);
        @(negedge clk);
        #1;
        st_in = st; v_in = v; b_in = bt;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0);
    endtask

    int t0, t1, c6, c7;

    initial begin
        repeat (3) @(negedge clk);
        #1;
        check("rst_outs", 0, 32'({b0.enc_en, b0.enc_clr, b0.sym_valid, b0.busy, b0.src_ready}), 32'd0);
        check("rst_frame_cnt", 0, 32'(b0.frame_cnt), 32'd0);
        check("rst_state", 1, 32'(b1.fsm_state), 32'd0);
        reset = 1'b1;
        idle(3);

        // Single frame, bits 1,0,1,1.
        drive(1, 0, 0); t0 = cyc;
        drive(0, 1, 1); drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 1);
        idle(12); t1 = cyc;
        check("t1_clr", 0, count_of(0, B_CLR, t0, t1), 1);
        check("t1_en", 0, count_of(0, B_EN, t0, t1), 6);
        check("t1_sv", 0, count_of(0, B_SV, t0, t1), 6);
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = t0; i < t1; i++) begin
            if (tr[0][i][B_EN] && exp_q.size() > 0) check("t1_din", 0, 32'(tr[0][i][B_DIN]), 32'(exp_q.pop_front()));
        end
        check("t1_din_left", 0, exp_q.size(), 0);
        check("t1_sof_lat", 0, nth_of(0, B_SOF, 1, t0, t1) - nth_of(0, B_EN, 1, t0, t1), LAT);
        check("t1_eof_lat", 0, last_of(0, B_EOF, t0, t1) - last_of(0, B_EN, t0, t1), LAT);
        check("t1_sof_first_sv", 0, nth_of(0, B_SOF, 1, t0, t1), nth_of(0, B_SV, 1, t0, t1));
        check("t1_eof_last_sv", 0, last_of(0, B_EOF, t0, t1), last_of(0, B_SV, t0, t1));
        check("t1_frame_cnt", 0, 32'(b0.frame_cnt), 1);
        check("t1_model_fc", 0, 32'(m_fc[0]), 1);

        // Underrun: three idle source cycles after the second bit.
        drive(1, 0, 0); t0 = cyc;
        drive(0, 1, 1); drive(0, 1, 1);
        drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
        drive(0, 1, 0); drive(0, 1, 1);
        idle(12); t1 = cyc;
        check("t2_und", 0, count_of(0, B_UND, t0, t1), 3);
        check("t2_und_run", 0, nth_of(0, B_UND, 3, t0, t1) - nth_of(0, B_UND, 1, t0, t1), 2);
        check("t2_hole", 0, nth_of(0, B_EN, 3, t0, t1) - nth_of(0, B_EN, 2, t0, t1), 4);
        check("t2_en", 0, count_of(0, B_EN, t0, t1), 6);
        check("t2_sv", 0, count_of(0, B_SV, t0, t1), 6);
        check("t2_frame_cnt", 0, 32'(b0.frame_cnt), 2);

        // Two frames with start held; dut1 shows the inter-frame gap.
        drive(1, 0, 0); t0 = cyc;
        for (int i = 1; i <= 22; i++) drive(i <= 9, 1'b1, 1'(i));
        idle(12); t1 = cyc;
        check("t3_en", 0, count_of(0, B_EN, t0, t1), 12);
        check("t3_en_span", 0, last_of(0, B_EN, t0, t1) - nth_of(0, B_EN, 1, t0, t1), 11);
        check("t3_clr", 0, count_of(0, B_CLR, t0, t1), 1);
        check("t3_sof", 0, count_of(0, B_SOF, t0, t1), 2);
        check("t3_eof", 0, count_of(0, B_EOF, t0, t1), 2);
        check("t3_frame_cnt", 0, 32'(b0.frame_cnt), 4);
        c6 = nth_of(1, B_EN, 6, t0, t1);
        c7 = nth_of(1, B_EN, 7, t0, t1);
        check("t4_en_gap", 1, c7 - c6 - 1, GAP_B);
        check("t4_rdy_gap", 1, (c7 - c6) - count_of(1, B_RDY, c6, c7), GAP_B);
        check("t4_en", 1, count_of(1, B_EN, t0, t1), 12);
        check("t4_frame_cnt", 1, 32'(b1.frame_cnt), 4);

        // start dropped after the second data bit.
        drive(1, 0, 0); t0 = cyc;
        drive(1, 1, 1); drive(1, 1, 0);
        repeat (6) drive(0, 1, 1);
        idle(12); t1 = cyc;
        check("t5_en", 0, count_of(0, B_EN, t0, t1), 6);
        check("t5_busy_fall", 0, last_of(0, B_BUSY, t0, t1) - last_of(0, B_EN, t0, t1), LAT);
        check("t5_idle_rdy", 0, 32'({tr[0][t1-1][B_RDY], tr[0][t1-1][B_BUSY]}), 0);
        check("t5_state", 0, 32'(b0.fsm_state), 0);
        check("t5_frame_cnt", 0, 32'(b0.frame_cnt), 5);

        // Asynchronous reset in the middle of the data phase.
        drive(1, 0, 0); t0 = cyc;
        drive(1, 1, 1); drive(1, 1, 0);
        @(negedge clk);
        #3;
        reset = 1'b0;
        #1;
        st_in = 1'b0; v_in = 1'b0;
        check("t6_outs", 0, 32'({b0.enc_en, b0.enc_din, b0.enc_clr, b0.sym_valid, b0.sym_sof,
                                  b0.sym_eof, b0.underrun, b0.src_ready, b0.busy}), 0);
        check("t6_frame_cnt", 0, 32'(b0.frame_cnt), 0);
        check("t6_frame_cnt", 1, 32'(b1.frame_cnt), 0);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b1;
        idle(4); t1 = cyc;
        check("t6_no_eof", 0, count_of(0, B_EOF, t0, t1), 0);
        drive(1, 0, 0); t0 = cyc;
        drive(0, 1, 0); drive(0, 1, 1); drive(0, 1, 1); drive(0, 1, 0);
        idle(12); t1 = cyc;
        check("t6_clr", 0, count_of(0, B_CLR, t0, t1), 1);
        check("t6_en", 0, count_of(0, B_EN, t0, t1), 6);
        check("t6_eof", 0, count_of(0, B_EOF, t0, t1), 1);
        check("t6_frame_cnt_new", 0, 32'(b0.frame_cnt), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
